// File: rtl/ahb_master_req_ctrl.sv
// Purpose : AHB master request/burst controller; takes one command, requests the bus, issues NONSEQ/SEQ beats.
// Latency : first address beat is presented one cycle after command accept; beat/xfer pulses are same-cycle with hgrant.
// Backpressure: hgrant=0 freezes the current beat; cmd_ready is low from command accept until IDLE is re-entered.
//
// Ports
//   hclk, hreset              clock, synchronous active-high reset
//   cmd_valid/ready           command handshake from local logic (accepted only in IDLE)
//   cmd_addr/burst/write      start address, burst type, direction of the command
//   hreq                      request toward the slave arbiter
//   hgrant                    beat accepted by arbiter (already qualified with ~hwait)
//   haddr/htrans/hburst/hwrite  address-phase outputs
//   beat_done, xfer_done      per-beat pulse and last-beat pulse
//   timeout_err               grant-wait timeout pulse (only with MASTER_REQ_TIMEOUT_EN)
//
// Optional feature macro: MASTER_REQ_TIMEOUT_EN (grant-wait timeout in REQ).

package ahb_master_req_ctrl_pkg;
    typedef enum logic [2:0] {
        HB_SINGLE = 3'd0,
        HB_INCR   = 3'd1,
        HB_WRAP4  = 3'd2,
        HB_INCR4  = 3'd3,
        HB_WRAP8  = 3'd4,
        HB_INCR8  = 3'd5,
        HB_WRAP16 = 3'd6,
        HB_INCR16 = 3'd7
    } hburst_type;
endpackage

module ahb_master_req_ctrl
    import ahb_master_req_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  hburst_type        cmd_burst,
    input  logic              cmd_write,
    output logic              hreq,
    input  logic              hgrant,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output hburst_type        hburst,
    output logic              hwrite,
`ifdef MASTER_REQ_TIMEOUT_EN
    output logic              timeout_err,
`endif
    output logic              beat_done,
    output logic              xfer_done
);

    localparam int STEP    = DATA_W / 8;
    localparam int STEP_LG = $clog2(STEP);

    // Elaboration-time guard on configuration.
    if (DATA_W < 8 || (DATA_W & (DATA_W - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("ahb_master_req_ctrl: DATA_W must be a power of 2 >= 8 and TIMEOUT_CYC >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        beat_cnt;
    logic [4:0]        beats;
    logic              is_wrap;
    logic              last_beat;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] wrap_mask;
    logic [ADDR_W-1:0] addr_nxt;

`ifdef MASTER_REQ_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_hit;
`endif

    // Burst length and wrap attribute of the latched command.
    always_comb begin
        beats   = 5'd1;
        is_wrap = 1'b0;
        case (hburst)
            HB_WRAP4:  begin beats = 5'd4;  is_wrap = 1'b1; end
            HB_INCR4:  beats = 5'd4;
            HB_WRAP8:  begin beats = 5'd8;  is_wrap = 1'b1; end
            HB_INCR8:  beats = 5'd8;
            HB_WRAP16: begin beats = 5'd16; is_wrap = 1'b1; end
            HB_INCR16: beats = 5'd16;
            default:   beats = 5'd1;
        endcase
    end

    // beat_cnt is 0 in REQ, so one-beat bursts finish there without a special case.
    assign last_beat = ({1'b0, beat_cnt} == (beats - 5'd1));

    // Wrapping bursts only let the bits below the wrap boundary (beats*step) carry.
    always_comb begin
        addr_inc  = haddr + ADDR_W'(STEP);
        wrap_mask = (ADDR_W'(beats) << STEP_LG) - ADDR_W'(1);
        addr_nxt  = is_wrap ? ((haddr & ~wrap_mask) | (addr_inc & wrap_mask)) : addr_inc;
    end

    // State register.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and state-decoded outputs.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        hreq      = 1'b0;
        htrans    = 2'b00;
        beat_done = 1'b0;
        xfer_done = 1'b0;
`ifdef MASTER_REQ_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                hreq   = 1'b1;
                htrans = 2'b10;
                if (hgrant) begin
                    beat_done = 1'b1;
                    if (last_beat) begin
                        xfer_done = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_XFER;
                    end
                end
`ifdef MASTER_REQ_TIMEOUT_EN
                // A grant in the limit cycle takes priority over the timeout.
                else if (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = ST_IDLE;
                end
`endif
            end
            ST_XFER: begin
                hreq   = 1'b1;
                htrans = 2'b11;
                if (hgrant) begin
                    beat_done = 1'b1;
                    if (last_beat) begin
                        xfer_done = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Command capture and per-beat address/count advance.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            haddr    <= '0;
            hburst   <= HB_SINGLE;
            hwrite   <= 1'b0;
            beat_cnt <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        haddr    <= cmd_addr;
                        hburst   <= cmd_burst;
                        hwrite   <= cmd_write;
                        beat_cnt <= 4'd0;
                    end
                end
                ST_REQ, ST_XFER: begin
                    // The final beat leaves haddr on the last address issued.
                    if (hgrant && !last_beat) begin
                        haddr    <= addr_nxt;
                        beat_cnt <= beat_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MASTER_REQ_TIMEOUT_EN
    // Counts ungranted REQ cycles; IDLE clears it so every REQ entry starts at 0.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            wait_cnt <= '0;
        end else if (state == ST_IDLE) begin
            wait_cnt <= '0;
        end else if (state == ST_REQ && !hgrant) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    assign timeout_err = timeout_hit;
`endif

endmodule
